// File: rtl/int_vector_seq_pkg.sv
// Shared encodings for the interrupt/vector sequencer: source codes, P-register
// bit positions and one-hot state indices.
package int_vector_seq_pkg;

  typedef enum logic [1:0] {
    SRC_RESET = 2'b00,
    SRC_NMI   = 2'b01,
    SRC_IRQ   = 2'b10,
    SRC_BRK   = 2'b11
  } src_e;

  localparam int P_CARRY  = 0;
  localparam int P_ZERO   = 1;
  localparam int P_IRQ    = 2;
  localparam int P_BCD    = 3;
  localparam int P_BREAK  = 4;
  localparam int P_UNUSED = 5;
  localparam int P_OVF    = 6;
  localparam int P_NEG    = 7;

  // PUSH_H..FIN are contiguous so busy is a single slice reduction
  localparam int ST_IDLE     = 0;
  localparam int ST_PUSH_H   = 1;
  localparam int ST_PUSH_L   = 2;
  localparam int ST_PUSH_P   = 3;
  localparam int ST_VEC_L    = 4;
  localparam int ST_VEC_H    = 5;
  localparam int ST_FIN      = 6;
  localparam int ST_RST_PEND = 7;
  localparam int NUM_ST      = 8;

endpackage

// File: rtl/int_vector_seq_if.sv
// Memory-bus side of the sequencer; the bus mux watches busy to hand over ownership.
interface int_vector_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              busy;
    logic [DATA_W-1:0] rd_data;

    modport master (output address, wr_data, wr_en, busy, input rd_data);
    modport slave  (input address, wr_data, wr_en, busy, output rd_data);
endinterface

// File: rtl/int_vector_seq_nmi_edge_det.sv
// Registered falling-edge detector for nmi_n with a sticky pending flag.
// A new edge wins over a simultaneous clear so no NMI is ever dropped.
module int_vector_seq_nmi_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic nmi_n,
    input  logic clr,
    output logic pend
);
    logic nmi_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nmi_q <= 1'b1;
            pend  <= 1'b0;
        end else begin
            nmi_q <= nmi_n;
            if (nmi_q && !nmi_n)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;
        end
    end
endmodule

// File: rtl/int_vector_seq.sv
// RESET/NMI/IRQ/BRK entry sequencer: pushes PC and P, fetches the vector and
// hands the new PC/S/P back to the core.
module int_vector_seq
    import int_vector_seq_pkg::*;
#(
    parameter int                       ADDR_W     = 16,
    parameter int                       DATA_W     = 8,
    parameter logic [ADDR_W-DATA_W-1:0] STACK_PAGE = 8'h01,
    parameter logic [ADDR_W-1:0]        NMI_VEC    = 16'hFFFA,
    parameter logic [ADDR_W-1:0]        RESET_VEC  = 16'hFFFC,
    parameter logic [ADDR_W-1:0]        IRQ_VEC    = 16'hFFFE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              boundary,
    input  logic              irq_n,
    input  logic              nmi_n,
    input  logic              brk_req,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] p_in,
    input  logic [DATA_W-1:0] s_in,
    int_vector_seq_if.master  bus,
    output logic              done,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] s_out,
    output logic [DATA_W-1:0] p_out,
    output logic [1:0]        src
);
    localparam logic [NUM_ST-1:0] IDLE     = NUM_ST'(1) << ST_IDLE;
    localparam logic [NUM_ST-1:0] PUSH_H   = NUM_ST'(1) << ST_PUSH_H;
    localparam logic [NUM_ST-1:0] PUSH_L   = NUM_ST'(1) << ST_PUSH_L;
    localparam logic [NUM_ST-1:0] PUSH_P   = NUM_ST'(1) << ST_PUSH_P;
    localparam logic [NUM_ST-1:0] VEC_L    = NUM_ST'(1) << ST_VEC_L;
    localparam logic [NUM_ST-1:0] VEC_H    = NUM_ST'(1) << ST_VEC_H;
    localparam logic [NUM_ST-1:0] FIN      = NUM_ST'(1) << ST_FIN;
    localparam logic [NUM_ST-1:0] RST_PEND = NUM_ST'(1) << ST_RST_PEND;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] s;
        src_e              src;
    } ctx_t;

    logic [NUM_ST-1:0] state, state_nx;
    ctx_t              ctx;
    logic [DATA_W-1:0] pcl;
    logic              nmi_pend, nmi_clr, hijack, accept, pushing;
    src_e              acc_src;
    logic [ADDR_W-1:0] vec;
    logic [DATA_W-1:0] s_m1, s_m2, s_m3, p_push;

    int_vector_seq_nmi_edge_det u_nmi (
        .clk    (clk),
        .resetn (resetn),
        .nmi_n  (nmi_n),
        .clr    (nmi_clr),
        .pend   (nmi_pend)
    );

    always_comb begin
        accept  = 1'b0;
        acc_src = SRC_IRQ;
        if (state[ST_IDLE] && boundary) begin
            if (nmi_pend) begin
                accept  = 1'b1;
                acc_src = SRC_NMI;
            end else if (brk_req) begin
                accept  = 1'b1;
                acc_src = SRC_BRK;
            end else if (!irq_n && !p_in[P_IRQ]) begin
                accept  = 1'b1;
                acc_src = SRC_IRQ;
            end
        end
    end

    // An NMI that lands while IRQ/BRK is still pushing steals the vector fetch
    assign hijack  = state[ST_PUSH_P] && nmi_pend &&
                     (ctx.src == SRC_IRQ || ctx.src == SRC_BRK);
    assign nmi_clr = state[ST_PUSH_P] && (ctx.src == SRC_NMI || hijack);

    always_comb begin
        case (state)
            RST_PEND: state_nx = PUSH_H;
            IDLE:     state_nx = accept ? PUSH_H : IDLE;
            PUSH_H:   state_nx = PUSH_L;
            PUSH_L:   state_nx = PUSH_P;
            PUSH_P:   state_nx = VEC_L;
            VEC_L:    state_nx = VEC_H;
            VEC_H:    state_nx = FIN;
            FIN:      state_nx = IDLE;
            default:  state_nx = RST_PEND;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RST_PEND;
            ctx   <= '0;
            pcl   <= '0;
        end else begin
            state <= state_nx;
            if (state[ST_RST_PEND] || accept) begin
                ctx.pc  <= pc_in;
                ctx.p   <= p_in;
                ctx.s   <= s_in;
                ctx.src <= state[ST_RST_PEND] ? SRC_RESET : acc_src;
            end
            if (hijack)
                ctx.src <= SRC_NMI;
            if (state[ST_VEC_H])
                pcl <= bus.rd_data;
        end
    end

    always_comb begin
        case (ctx.src)
            SRC_RESET: vec = RESET_VEC;
            SRC_NMI:   vec = NMI_VEC;
            default:   vec = IRQ_VEC;
        endcase
    end

    assign s_m1 = ctx.s - DATA_W'(1);
    assign s_m2 = ctx.s - DATA_W'(2);
    assign s_m3 = ctx.s - DATA_W'(3);

    always_comb begin
        p_push           = ctx.p;
        p_push[P_UNUSED] = 1'b1;
        p_push[P_BREAK]  = (ctx.src == SRC_BRK);
    end

    always_comb begin
        bus.address = '0;
        bus.wr_data = '0;
        if (state[ST_PUSH_H]) begin
            bus.address = {STACK_PAGE, ctx.s};
            bus.wr_data = DATA_W'(ctx.pc >> DATA_W);
        end else if (state[ST_PUSH_L]) begin
            bus.address = {STACK_PAGE, s_m1};
            bus.wr_data = ctx.pc[DATA_W-1:0];
        end else if (state[ST_PUSH_P]) begin
            bus.address = {STACK_PAGE, s_m2};
            bus.wr_data = p_push;
        end else if (state[ST_VEC_L]) begin
            bus.address = vec;
        end else if (state[ST_VEC_H]) begin
            bus.address = vec + ADDR_W'(1);
        end
    end

    // Reset runs the push cycles as dummy reads so memory is left untouched
    assign pushing     = state[ST_PUSH_H] | state[ST_PUSH_L] | state[ST_PUSH_P];
    assign bus.wr_en   = pushing && (ctx.src != SRC_RESET);
    assign bus.busy    = |state[ST_FIN:ST_PUSH_H];
    assign done        = state[ST_FIN];
    assign src         = bus.busy ? ctx.src : 2'b00;
    assign pc_out      = done ? ADDR_W'({bus.rd_data, pcl}) : '0;
    assign s_out       = done ? s_m3 : '0;
    assign p_out       = done ? (ctx.p | DATA_W'(1 << P_IRQ)) : '0;

endmodule

// File: tb/tb_int_vector_seq.sv
// Randomised scoreboard bench for int_vector_seq: the driver queues expected bus
// cycles and hand-off values, a negedge monitor pops and compares them.
module tb_int_vector_seq;

    localparam logic [1:0] S_RST = 2'b00, S_NMI = 2'b01, S_IRQ = 2'b10, S_BRK = 2'b11;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
        logic [1:0]  src;
    } bus_t;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  s;
        logic [7:0]  p;
        logic [1:0]  src;
        int          cyc;
    } fin_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        boundary = 1'b0, irq_n = 1'b1, nmi_n = 1'b1, brk_req = 1'b0;
    logic [15:0] pc_in = '0;
    logic [7:0]  p_in = '0, s_in = '0;
    logic        done;
    logic [15:0] pc_out;
    logic [7:0]  s_out, p_out;
    logic [1:0]  src;
    logic [7:0]  rd_q;
    logic [7:0]  vbytes [0:7];

    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    bit   m_pend = 1'b0;
    bus_t exp_bus[$];
    fin_t exp_fin[$];

    int_vector_seq_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    int_vector_seq dut (
        .clk      (clk),
        .resetn   (resetn),
        .boundary (boundary),
        .irq_n    (irq_n),
        .nmi_n    (nmi_n),
        .brk_req  (brk_req),
        .pc_in    (pc_in),
        .p_in     (p_in),
        .s_in     (s_in),
        .bus      (bus),
        .done     (done),
        .pc_out   (pc_out),
        .s_out    (s_out),
        .p_out    (p_out),
        .src      (src)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rd_lookup(input logic [15:0] a);
        logic [15:0] d;
        d = a - 16'hFFFA;
        if (a >= 16'hFFFA) return vbytes[d[2:0]];
        return 8'hA5 ^ a[7:0];
    endfunction

    // Memory returns data for the address presented one cycle earlier
    always @(posedge clk) rd_q <= rd_lookup(bus.address);
    assign bus.rd_data = rd_q;

    function automatic logic [15:0] vec_of(input logic [1:0] s);
        if (s == S_RST) return 16'hFFFC;
        if (s == S_NMI) return 16'hFFFA;
        return 16'hFFFE;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.address, bus.wr_data, bus.wr_en, bus.busy, done, pc_out, s_out, p_out, src});
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_seq(input logic [1:0] acc, input logic [1:0] eff, input logic [15:0] pc,
                            input logic [7:0] p, input logic [7:0] s, input int c, input bit fin);
        logic [15:0] v;
        logic [7:0]  pp;
        fin_t        f;
        v      = vec_of(eff);
        pp     = p | 8'h20;
        pp[4]  = (acc == S_BRK);
        exp_bus.push_back('{{8'h01, s},         acc != S_RST, pc[15:8], acc});
        exp_bus.push_back('{{8'h01, s - 8'd1},  acc != S_RST, pc[7:0],  acc});
        exp_bus.push_back('{{8'h01, s - 8'd2},  acc != S_RST, pp,       acc});
        exp_bus.push_back('{v,                  1'b0,         8'h00,    eff});
        exp_bus.push_back('{v + 16'd1,          1'b0,         8'h00,    eff});
        if (fin) begin
            f.pc  = {rd_lookup(v + 16'd1), rd_lookup(v)};
            f.s   = s - 8'd3;
            f.p   = p | 8'h04;
            f.src = eff;
            f.cyc = c + 6;
            exp_fin.push_back(f);
        end
    endtask

    // Offer one boundary with the given inputs; nmi_k is the cycle (relative to
    // the offer) in which a one-cycle nmi_n low pulse is driven, -1 for none.
    task automatic issue(input logic brk, input logic irqn, input logic [7:0] p,
                         input logic [15:0] pc, input logic [7:0] s, input int nmi_k);
        logic [1:0] acc, eff;
        bit         ok;
        int         k_nmi;
        k_nmi = nmi_k;
        ok    = 1'b1;
        acc   = S_IRQ;
        if (m_pend) acc = S_NMI;
        else if (brk) acc = S_BRK;
        else if (!irqn && !p[2]) acc = S_IRQ;
        else ok = 1'b0;
        if (ok && acc == S_NMI && k_nmi >= 0 && k_nmi <= 3) k_nmi = -1;
        eff = acc;
        if (ok) begin
            if (acc == S_NMI) m_pend = 1'b0;
            if (k_nmi >= 0 && k_nmi <= 2) eff = S_NMI;
            else if (k_nmi >= 0) m_pend = 1'b1;
            push_seq(acc, eff, pc, p, s, cyc, 1'b1);
        end else if (k_nmi >= 0) begin
            m_pend = 1'b1;
        end
        brk_req = brk; irq_n = irqn; p_in = p; pc_in = pc; s_in = s; boundary = 1'b1;
        for (int k = 0; k < 8; k++) begin
            nmi_n = (k == k_nmi) ? 1'b0 : 1'b1;
            if (k > 0) begin
                if (ok && k <= 6) begin
                    // Requests while busy must be ignored
                    boundary = 1'($urandom_range(0, 1));
                    brk_req  = 1'($urandom_range(0, 1));
                    irq_n    = 1'($urandom_range(0, 1));
                    p_in     = 8'($urandom);
                    pc_in    = 16'($urandom);
                    s_in     = 8'($urandom);
                end else begin
                    boundary = 1'b0; brk_req = 1'b0; irq_n = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        nmi_n = 1'b1; boundary = 1'b0; brk_req = 1'b0; irq_n = 1'b1;
    endtask

    task automatic reset_release(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] s);
        pc_in = pc; p_in = p; s_in = s;
        boundary = 1'b0; brk_req = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;
        push_seq(S_RST, S_RST, pc, p, s, cyc, 1'b1);
        resetn = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin : mon
        bus_t b;
        fin_t f;
        if (resetn) begin
            if (done) begin
                if (exp_fin.size() == 0) begin
                    chk(1'b0, "unexpected_done", 64'(pc_out), 64'h0);
                end else begin
                    f = exp_fin.pop_front();
                    chk(pc_out === f.pc && s_out === f.s && p_out === f.p && src === f.src &&
                        bus.busy === 1'b1 && cyc == f.cyc, "done",
                        64'({pc_out, s_out, p_out, src, bus.busy, 16'(cyc)}),
                        64'({f.pc, f.s, f.p, f.src, 1'b1, 16'(f.cyc)}));
                end
            end else if (bus.busy) begin
                if (exp_bus.size() == 0) begin
                    chk(1'b0, "unexpected_busy", 64'(bus.address), 64'h0);
                end else begin
                    b = exp_bus.pop_front();
                    chk(bus.address === b.addr && bus.wr_en === b.we && src === b.src &&
                        (!b.we || bus.wr_data === b.data), "bus_cycle",
                        64'({bus.address, bus.wr_en, bus.wr_data, src}),
                        64'({b.addr, b.we, b.data, b.src}));
                end
            end else begin
                chk(bus.wr_en === 1'b0, "idle_wr_en", 64'(bus.wr_en), 64'h0);
            end
        end
    end

    initial begin
        int ks [5];
        int r;
        ks = '{0, 1, 2, 4, 5};
        vbytes[0] = 8'($urandom); vbytes[1] = 8'($urandom);
        vbytes[2] = 8'h34;        vbytes[3] = 8'h12;
        vbytes[4] = 8'($urandom); vbytes[5] = 8'($urandom);
        vbytes[6] = 8'h00;        vbytes[7] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk(outs() === 64'h0, "reset_outputs", outs(), 64'h0);
        reset_release(16'h0000, 8'h00, 8'hFD);

        issue(1'b0, 1'b0, 8'h00, 16'hC005, 8'hFF, -1);          // plain IRQ

        boundary = 1'b1; irq_n = 1'b0; p_in = 8'h04; brk_req = 1'b0;
        repeat (10) begin @(posedge clk); #1; end                // masked IRQ
        boundary = 1'b0; irq_n = 1'b1;

        issue(1'b1, 1'b0, 8'h81, 16'h2468, 8'hF0, -1);          // BRK beats IRQ
        issue(1'b0, 1'b0, 8'h00, 16'h4321, 8'hE0, 2);           // NMI hijacks IRQ
        issue(1'b0, 1'b1, 8'h04, 16'h1111, 8'hD0, 0);           // edge while idle
        issue(1'b0, 1'b1, 8'h04, 16'h2222, 8'hC0, 4);           // NMI, second edge
        issue(1'b0, 1'b1, 8'h04, 16'h3333, 8'hB0, -1);          // second NMI
        issue(1'b1, 1'b1, 8'h00, 16'h5A5A, 8'h01, -1);          // stack wrap

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            issue(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
                  16'($urandom), 8'($urandom), (r < 5) ? -1 : ks[r-5]);
        end

        // Abort a BRK in VEC_H with an asynchronous reset
        push_seq(S_BRK, S_BRK, 16'h8000, 8'h00, 8'h40, cyc, 1'b0);
        brk_req = 1'b1; boundary = 1'b1; p_in = 8'h00; pc_in = 16'h8000; s_in = 8'h40;
        repeat (5) begin @(posedge clk); #1; boundary = 1'b0; brk_req = 1'b0; end
        @(negedge clk); #1;
        resetn = 1'b0;
        #1;
        chk(outs() === 64'h0, "abort_outputs", outs(), 64'h0);
        chk(exp_bus.size() == 0, "abort_queue", 64'(exp_bus.size()), 64'h0);
        exp_bus.delete();
        m_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_release(16'hBEEF, 8'h42, 8'hFD);

        repeat (3) begin @(posedge clk); #1; end
        chk(exp_bus.size() == 0 && exp_fin.size() == 0, "drain",
            64'({exp_bus.size(), exp_fin.size()}), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_vector_seq.md
Name: int_vector_seq

Overview:
- Parametrised interrupt/vector sequencer for the 6502 core. Runs the full RESET, NMI, IRQ and BRK entry sequence: stack pushes of PC and P, vector fetch, and hand-off of the new PC/S/P to the core.
- Generalises the core's fixed reset-vector fetch to all four sources, with configurable vectors, stack page and widths.
- Sits between the core's instruction-boundary logic and the memory bus mux. It owns the bus only while busy=1.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data and register width.
- STACK_PAGE, 8'h01, upper address byte for stack accesses.
- NMI_VEC, 16'hFFFA, NMI vector LSB address. MSB is at NMI_VEC+1.
- RESET_VEC, 16'hFFFC, reset vector LSB address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector LSB address.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- boundary  in  1  core is at an instruction boundary and may be preempted
- irq_n  in  1  level-sensitive IRQ, active low
- nmi_n  in  1  edge-sensitive NMI, falling edge
- brk_req  in  1  core decoded BRK (valid with boundary)
- pc_in  in  ADDR_W  return PC to push
- p_in  in  DATA_W  status register
- s_in  in  DATA_W  stack pointer
- rd_data  in  DATA_W  memory read data
- address  out  ADDR_W  bus address
- wr_data  out  DATA_W  bus write data
- wr_en  out  1  bus write strobe
- busy  out  1  sequencer owns bus
- done  out  1  one-cycle pulse; pc_out/s_out/p_out valid
- pc_out  out  ADDR_W  vector target
- s_out  out  DATA_W  updated stack pointer
- p_out  out  DATA_W  updated status (I set)
- src  out  2  00 RESET, 01 NMI, 10 IRQ, 11 BRK; valid while busy/done

Behaviour:
- Reset (async, resetn=0): all outputs 0. nmi_pend=0, nmi_n history register=1. State=RST_PEND.
- First clk edge with resetn=1: a RESET sequence starts unconditionally. boundary is ignored.
- Memory timing: rd_data corresponds to the address driven in the previous cycle.
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, FIN, RST_PEND.
- NMI detect: nmi_pend is set on a registered 1->0 transition of nmi_n. It clears when an NMI sequence enters VEC_L.
- Acceptance, in IDLE with boundary=1. Priority is NMI > BRK > IRQ:
  - NMI if nmi_pend.
  - BRK if brk_req.
  - IRQ if irq_n=0 and p_in[2]=0.
  - Otherwise stay IDLE, busy=0.
  - On accept, latch pc_in, p_in, s_in and src. Next state is PUSH_H.
- Bus cycles, one per clock; busy=1 from PUSH_H through FIN:
  - PUSH_H: address={STACK_PAGE,S}, wr_data=PC[15:8].
  - PUSH_L: address={STACK_PAGE,S-1}, wr_data=PC[7:0].
  - PUSH_P: address={STACK_PAGE,S-2}, wr_data=P with bit5=1 and bit4=(src==BRK).
  - VEC_L: address=vector. Vector selection: RESET→RESET_VEC, NMI→NMI_VEC, IRQ/BRK→IRQ_VEC.
  - VEC_H: address=vector+1; capture rd_data as PCL.
  - FIN: done=1, pc_out={rd_data,PCL}, s_out=S-3 (mod 256), p_out=P with bit2=1 and bit4 unchanged. Next state is IDLE.
- wr_en=1 in the PUSH states, except during RESET, where pushes are reads (wr_en=0) and S still decrements.
- Total latency from accept to done: 6 cycles.
- S arithmetic wraps mod 2^DATA_W. Example: S=8'h01 pushes at 0x0101, 0x0100, 0x01FF.
- NMI hijack: if nmi_pend rises during PUSH_H..PUSH_P of an IRQ/BRK sequence, the vector switches to NMI_VEC at VEC_L and src becomes 01. For a BRK, the pushed B bit stays as already written.
- An NMI edge arriving during an NMI sequence (after VEC_L) sets nmi_pend again. It is serviced at the next boundary.
- brk_req or IRQ while busy: ignored. The core holds them.
- resetn asserted mid-sequence: immediate abort to reset values. wr_en drops asynchronously.

Decomposition:
- Shared package/include (alongside opcodes.vh):
  - src encodings (SRC_RESET/NMI/IRQ/BRK).
  - P bit indices (NEG, OVF, UNUSED, BREAK, BCD, IRQ, ZERO, CARRY).
  - One-hot state indices.
- Sub-module nmi_edge_det: synchroniser-free registered falling-edge detector with a pending flag and a clear input.

Test Plan:
- Reset release, memory FFFC=34, FFFD=12, s_in=FD → done 6 cycles later; pc_out=1234, s_out=FA, wr_en never 1, src=00.
- IRQ, irq_n=0, p_in=00, pc_in=C005, s_in=FF → writes C0@01FF, 05@01FE, 20@01FD; reads FFFE/FFFF; p_out=04, s_out=FC.
- IRQ masked, p_in=04, irq_n=0, boundary=1 for 10 cycles → busy stays 0, no bus writes.
- BRK with simultaneous IRQ, p_in=81 → src=11; pushed P=B1; vector FFFE; p_out=85.
- IRQ accepted, NMI falling edge during PUSH_L → vector reads FFFA/FFFB, src=01 at done, nmi_pend=0 after; a second NMI edge is serviced at the next boundary.
- s_in=01 BRK → pushes at 0101, 0100, 01FF; s_out=FE. resetn pulled low in VEC_H → all outputs 0 at once, then reset sequence on release.
